two_level_cache_ctrl: RTL

Sequencing controller for the two-level direct-mapped cache (256-line L1, 512-line L2, 16-word blocks). It accepts one CPU read request at a time, probes L1, then L2, and runs the 16-beat block refill into L1 from L2 on an L2 hit, or into both levels from main memory on an L2 miss. It also keeps saturating per-level hit and miss statistics. It sits between the CPU port and the cache arrays and main-memory port.

---
 rtl/two_level_cache_ctrl_if.sv | 52 +++++
 rtl/two_level_cache_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/two_level_cache_ctrl_if.sv
// Bus bundle between the two-level cache controller and its environment:
// CPU request port, L1/L2 probe and read ports, main-memory burst port and
// the shared fill write port.
interface two_level_cache_ctrl_if #(
  parameter int BEAT_W = 4
);
  logic              cpu_req;
  logic [31:0]       cpu_addr;
  logic              cpu_ready;
  logic              cpu_done;
  logic [1:0]        cpu_level;

  logic              l1_lookup;
  logic              l1_hit;
  logic              l2_lookup;
  logic              l2_hit;
  logic [BEAT_W-1:0] l2_rd_word;
  logic [31:0]       l2_rd_data;

  logic              mem_req;
  logic [31:0]       mem_addr;
  logic              mem_valid;
  logic [31:0]       mem_data;

  logic              fill_we;
  logic              fill_l1;
  logic              fill_l2;
  logic [BEAT_W-1:0] fill_word;
  logic [31:0]       fill_data;

  // controller side
  modport master (
    input  cpu_req, cpu_addr,
    output cpu_ready, cpu_done, cpu_level,
    output l1_lookup, l2_lookup, l2_rd_word,
    input  l1_hit, l2_hit, l2_rd_data,
    output mem_req, mem_addr,
    input  mem_valid, mem_data,
    output fill_we, fill_l1, fill_l2, fill_word, fill_data
  );

  // CPU, cache arrays and memory side
  modport slave (
    output cpu_req, cpu_addr,
    input  cpu_ready, cpu_done, cpu_level,
    input  l1_lookup, l2_lookup, l2_rd_word,
    output l1_hit, l2_hit, l2_rd_data,
    input  mem_req, mem_addr,
    output mem_valid, mem_data,
    input  fill_we, fill_l1, fill_l2, fill_word, fill_data
  );
endinterface

// File: rtl/two_level_cache_ctrl.sv
// Sequencing controller for a two-level direct-mapped cache.
// One CPU read at a time: probe L1, then L2, then refill the block into L1
// from L2 (L2 hit) or into both levels from main memory (L2 miss).
// Keeps saturating hit/miss statistics per level.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a request, latch address on cpu_req
// L1_LOOK  | strobe l1_lookup
// L1_CHK   | sample l1_hit: hit -> DONE, miss -> L2_LOOK
// L2_LOOK  | strobe l2_lookup
// L2_CHK   | sample l2_hit: hit -> L2_COPY, miss -> MEM_FILL
// L2_COPY  | copy one word per cycle from L2 into L1
// MEM_FILL | hold mem_req, write each valid beat into L1 and L2
// DONE     | one-cycle cpu_done with the source level
module two_level_cache_ctrl #(
  parameter int BLOCK_WORDS = 16,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  two_level_cache_ctrl_if.master bus,
  output logic [CNT_W-1:0]      l1_hit_cnt,
  output logic [CNT_W-1:0]      l2_hit_cnt,
  output logic [CNT_W-1:0]      miss_cnt
);
  localparam int BEAT_W = $clog2(BLOCK_WORDS);
  // byte offset within a block of 32-bit words
  localparam int OFF_W = BEAT_W + 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, L1_LOOK, L1_CHK, L2_LOOK, L2_CHK, L2_COPY, MEM_FILL, DONE
  } state_t;

  state_t              state, state_nx;
  logic [31-OFF_W:0]   blk_q;
  logic [BEAT_W-1:0]   beat;
  logic [1:0]          level, level_nx;
  logic                latch, beat_clr, beat_inc;
  logic                inc_l1, inc_l2, inc_miss;

  // the memory address only carries the block number, offset bits are zero
  assign bus.mem_addr = {blk_q, {OFF_W{1'b0}}};

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state and decoded outputs
  always_comb begin
    state_nx       = state;
    level_nx       = level;
    latch          = 1'b0;
    beat_clr       = 1'b0;
    beat_inc       = 1'b0;
    inc_l1         = 1'b0;
    inc_l2         = 1'b0;
    inc_miss       = 1'b0;
    bus.cpu_ready  = 1'b0;
    bus.cpu_done   = 1'b0;
    bus.cpu_level  = 2'd0;
    bus.l1_lookup  = 1'b0;
    bus.l2_lookup  = 1'b0;
    bus.l2_rd_word = '0;
    bus.mem_req    = 1'b0;
    bus.fill_we    = 1'b0;
    bus.fill_l1    = 1'b0;
    bus.fill_l2    = 1'b0;
    bus.fill_word  = '0;
    bus.fill_data  = 32'd0;
    case (state)
      IDLE: begin
        bus.cpu_ready = 1'b1;
        if (bus.cpu_req) begin
          latch    = 1'b1;
          state_nx = L1_LOOK;
        end
      end
      L1_LOOK: begin
        bus.l1_lookup = 1'b1;
        state_nx      = L1_CHK;
      end
      L1_CHK: begin
        if (bus.l1_hit) begin
          inc_l1   = 1'b1;
          level_nx = 2'd0;
          state_nx = DONE;
        end else begin
          state_nx = L2_LOOK;
        end
      end
      L2_LOOK: begin
        bus.l2_lookup = 1'b1;
        state_nx      = L2_CHK;
      end
      L2_CHK: begin
        beat_clr = 1'b1;
        if (bus.l2_hit) begin
          inc_l2   = 1'b1;
          level_nx = 2'd1;
          state_nx = L2_COPY;
        end else begin
          inc_miss = 1'b1;
          level_nx = 2'd2;
          state_nx = MEM_FILL;
        end
      end
      L2_COPY: begin
        bus.l2_rd_word = beat;
        bus.fill_we    = 1'b1;
        bus.fill_l1    = 1'b1;
        bus.fill_word  = beat;
        bus.fill_data  = bus.l2_rd_data;
        beat_inc       = 1'b1;
        if (beat == LAST_BEAT) state_nx = DONE;
      end
      MEM_FILL: begin
        bus.mem_req = 1'b1;
        if (bus.mem_valid) begin
          bus.fill_we   = 1'b1;
          bus.fill_l1   = 1'b1;
          bus.fill_l2   = 1'b1;
          bus.fill_word = beat;
          bus.fill_data = bus.mem_data;
          beat_inc      = 1'b1;
          if (beat == LAST_BEAT) state_nx = DONE;
        end
      end
      DONE: begin
        bus.cpu_done  = 1'b1;
        bus.cpu_level = level;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // request address, beat counter and completion level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_q <= '0;
      beat  <= '0;
      level <= 2'd0;
    end else begin
      if (latch)         blk_q <= bus.cpu_addr[31:OFF_W];
      if (beat_clr)      beat  <= '0;
      else if (beat_inc) beat  <= beat + BEAT_W'(1);
      level <= level_nx;
    end
  end

  // saturating statistics counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l1_hit_cnt <= '0;
      l2_hit_cnt <= '0;
      miss_cnt   <= '0;
    end else begin
      if (inc_l1 && (l1_hit_cnt != {CNT_W{1'b1}}))   l1_hit_cnt <= l1_hit_cnt + CNT_W'(1);
      if (inc_l2 && (l2_hit_cnt != {CNT_W{1'b1}}))   l2_hit_cnt <= l2_hit_cnt + CNT_W'(1);
      if (inc_miss && (miss_cnt != {CNT_W{1'b1}}))   miss_cnt   <= miss_cnt + CNT_W'(1);
    end
  end
endmodule
